// File: rtl/spi_master_pkg.sv
// ============================================================================
// Module  : spi_master_pkg
// Brief   : Shared state encoding and constants for the SPI byte master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

    localparam int   BYTE_W              = 8;
    localparam int   DEFAULT_HALF_PERIOD = 8;
    localparam logic MOSI_IDLE           = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        HIGH  = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sck_half_timer.sv
// ============================================================================
// Module  : sck_half_timer
// Brief   : Phase timer; reloads on start, pulses done HALF_PERIOD cycles later.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sck_half_timer #(
    parameter int HALF_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int                 c_CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_PERIOD - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_run;

    // A start in the same cycle as done chains straight into the next phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign done = r_run && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/spi_byte_master.sv
// ============================================================================
// Module  : spi_byte_master
// Brief   : SPI mode-0 style byte master, SS low per byte, LSB first by
//           default; define SPI_BYTE_MASTER_MSB_FIRST_EN for MSB-first frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_master #(
    parameter int HALF_PERIOD = spi_master_pkg::DEFAULT_HALF_PERIOD,
    parameter int BYTE_W      = spi_master_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCK,
    output logic              SS,
    output logic              MOSI,
    input  logic              MISO
);

    import spi_master_pkg::*;

    localparam int                 c_CNT_W    = $clog2(BYTE_W);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(BYTE_W - 1);

    state_t              r_state, w_state_nxt;
    logic [BYTE_W-1:0]   r_tx_shift, w_tx_shift_nxt;
    logic [BYTE_W-1:0]   r_rx_shift, w_rx_shift_nxt;
    logic [c_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic                r_sck, w_sck_nxt;
    logic                r_ss, w_ss_nxt;
    logic                r_mosi, w_mosi_nxt;
    logic [BYTE_W-1:0]   r_rx_data, w_rx_data_nxt;
    logic                r_rx_valid, w_rx_valid_nxt;
    logic                w_done;
    logic                w_start;

    assign w_start = ((r_state == IDLE) && tx_valid) || (w_done && (r_state != GAP));

    sck_half_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .done  (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= MOSI_IDLE;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_sck      <= w_sck_nxt;
            r_ss       <= w_ss_nxt;
            r_mosi     <= w_mosi_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (tx_valid) w_state_nxt = LOW;
            LOW:     if (w_done)   w_state_nxt = HIGH;
            HIGH:    if (w_done)   w_state_nxt = (r_bit_cnt == c_LAST_BIT) ? TRAIL : LOW;
            TRAIL:   if (w_done)   w_state_nxt = GAP;
            GAP:     if (w_done)   w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs: next values of SCK/SS/MOSI and the datapath.
    always_comb begin
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_sck_nxt      = r_sck;
        w_ss_nxt       = r_ss;
        w_mosi_nxt     = r_mosi;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_tx_shift_nxt = tx_data;
                    w_rx_shift_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_sck_nxt      = 1'b0;
                    w_ss_nxt       = 1'b0;
`ifdef SPI_BYTE_MASTER_MSB_FIRST_EN
                    w_mosi_nxt     = tx_data[BYTE_W-1];
`else
                    w_mosi_nxt     = tx_data[0];
`endif
                end
            end
            LOW: begin
                if (w_done) begin
                    w_sck_nxt      = 1'b1;
`ifdef SPI_BYTE_MASTER_MSB_FIRST_EN
                    w_rx_shift_nxt = {r_rx_shift[BYTE_W-2:0], MISO};
`else
                    w_rx_shift_nxt = {MISO, r_rx_shift[BYTE_W-1:1]};
`endif
                end
            end
            HIGH: begin
                if (w_done) begin
                    w_sck_nxt = 1'b0;
                    if (r_bit_cnt != c_LAST_BIT) begin
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
`ifdef SPI_BYTE_MASTER_MSB_FIRST_EN
                        w_tx_shift_nxt = r_tx_shift << 1;
                        w_mosi_nxt     = r_tx_shift[BYTE_W-2];
`else
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_mosi_nxt     = r_tx_shift[1];
`endif
                    end
                end
            end
            TRAIL: begin
                if (w_done) begin
                    w_ss_nxt       = 1'b1;
                    w_mosi_nxt     = MOSI_IDLE;
                    w_rx_data_nxt  = r_rx_shift;
                    w_rx_valid_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign tx_ready = (r_state == IDLE);
    assign busy     = ~tx_ready;
    assign SCK      = r_sck;
    assign SS       = r_ss;
    assign MOSI     = r_mosi;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_master.sv
// ============================================================================
// Module  : tb_spi_byte_master
// Brief   : Self-checking bench for spi_byte_master with a bit-order-aware
//           slave model; honours SPI_BYTE_MASTER_MSB_FIRST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_byte_master;

    localparam int HP = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCK;
    logic       SS;
    logic       MOSI;
    logic       MISO;

    logic       loopback   = 1'b0;
    logic [7:0] slave_resp = 8'h00;
    logic       miso_slave = 1'b0;

    int errors = 0;
    int checks = 0;

    assign MISO = loopback ? MOSI : miso_slave;

    spi_byte_master #(
        .HALF_PERIOD (HP),
        .BYTE_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .SCK      (SCK),
        .SS       (SS),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    // Wire position i of a frame maps to this byte bit index.
    function automatic int wire_bit(input int i);
`ifdef SPI_BYTE_MASTER_MSB_FIRST_EN
        return 7 - i;
`else
        return i;
`endif
    endfunction

    function automatic logic exp_mosi(input logic [7:0] b, input int i);
        logic [7:0] v;
        v = b;
        return v[wire_bit(i)];
    endfunction

    // Observation and slave model, sampled on the falling clk edge.
    int   cyc         = 0;
    int   rises       = 0;
    int   ss_low_cnt  = 0;
    int   ss_high_run = 0;
    int   slave_idx   = 0;
    logic prev_sck    = 1'b0;
    logic prev_ss     = 1'b1;
    logic       mosi_q[$];
    logic [7:0] rx_q[$];
    int         rxv_cyc_q[$];
    int         ss_rise_q[$];
    int         gap_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (SCK === 1'b1 && prev_sck === 1'b0) begin
            mosi_q.push_back(MOSI);
            rises = rises + 1;
        end
        if (SS === 1'b0 && prev_ss === 1'b1) begin
            gap_q.push_back(ss_high_run);
            slave_idx  = 0;
            miso_slave = slave_resp[wire_bit(0)];
        end else if (SCK === 1'b0 && prev_sck === 1'b1 && SS === 1'b0 && slave_idx < 7) begin
            slave_idx  = slave_idx + 1;
            miso_slave = slave_resp[wire_bit(slave_idx)];
        end
        if (SS === 1'b1) ss_high_run = ss_high_run + 1;
        else begin
            ss_high_run = 0;
            ss_low_cnt  = ss_low_cnt + 1;
        end
        if (SS === 1'b1 && prev_ss === 1'b0) ss_rise_q.push_back(cyc);
        if (rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            rxv_cyc_q.push_back(cyc);
        end
        prev_sck = SCK;
        prev_ss  = SS;
    end

    // Drives one frame; lat = sampled cycles from the accept cycle to tx_ready high again.
    task automatic run_frame(input logic [7:0] b, input logic [7:0] resp,
                             input logic lb, output int lat);
        int c0;
        int n;
        slave_resp = resp;
        loopback   = lb;
        lat        = -1;
        n          = 0;
        @(negedge clk); #1;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        c0       = cyc;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (tx_ready !== 1'b1 && n < 300);
        if (tx_ready === 1'b1) lat = cyc - c0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        checks++; if (SCK !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", SCK); end
        checks++; if (SS !== 1'b1) begin errors++; $display("FAIL reset_ss: got %b expected 1", SS); end
        checks++; if (MOSI !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b expected 1", MOSI); end
        checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got ready=%b busy=%b expected 1/0", tx_ready, busy);
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_frame_a5();
        int m0, r0, s0, q0, lat;
        m0 = mosi_q.size(); r0 = rises; s0 = ss_low_cnt; q0 = rx_q.size();
        run_frame(8'hA5, 8'h00, 1'b0, lat);
        checks++; if (rises - r0 !== 8) begin errors++; $display("FAIL a5_rises: got %0d expected 8", rises - r0); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mosi_q.size() <= m0 + i || mosi_q[m0 + i] !== exp_mosi(8'hA5, i)) begin
                errors++; $display("FAIL a5_mosi_bit%0d: got %b expected %b", i,
                                   (mosi_q.size() > m0 + i) ? mosi_q[m0 + i] : 1'bx, exp_mosi(8'hA5, i));
            end
        end
        checks++; if (ss_low_cnt - s0 !== 17 * HP) begin
            errors++; $display("FAIL a5_ss_low: got %0d expected %0d", ss_low_cnt - s0, 17 * HP);
        end
        checks++; if (lat !== 18 * HP + 1) begin errors++; $display("FAIL a5_ready_latency: got %0d expected %0d", lat, 18 * HP + 1); end
        checks++; if (rx_q.size() - q0 !== 1) begin errors++; $display("FAIL a5_rx_pulses: got %0d expected 1", rx_q.size() - q0); end
    endtask

    task automatic test_loopback();
        int q0, e0, lat;
        q0 = rx_q.size(); e0 = ss_rise_q.size();
        run_frame(8'h3C, 8'h00, 1'b1, lat);
        checks++; if (rx_q.size() - q0 !== 1) begin errors++; $display("FAIL loop_pulses: got %0d expected 1", rx_q.size() - q0); end
        if (rx_q.size() > q0) begin
            checks++; if (rx_q[q0] !== 8'h3C) begin errors++; $display("FAIL loop_data: got %h expected 3c", rx_q[q0]); end
            checks++;
            if (ss_rise_q.size() <= e0 || rxv_cyc_q[q0] !== ss_rise_q[e0]) begin
                errors++; $display("FAIL loop_pulse_at_ss_rise: rx_valid at cycle %0d, SS rise not coincident", rxv_cyc_q[q0]);
            end
        end
        loopback = 1'b0;
    endtask

    task automatic test_slave_response();
        int q0, lat;
        q0 = rx_q.size();
        run_frame(8'h01, 8'h07, 1'b0, lat);
        checks++;
        if (rx_q.size() - q0 !== 1 || rx_q[q0] !== 8'h07) begin
            errors++; $display("FAIL slave_rx: got %h (pulses %0d) expected 07", rx_data, rx_q.size() - q0);
        end
    endtask

    task automatic test_back_to_back();
        int m0, g0, n;
        logic ok;
        m0 = mosi_q.size(); g0 = gap_q.size(); ok = 1'b1;
        slave_resp = 8'h00;
        @(negedge clk); #1;
        tx_data = 8'h00; tx_valid = 1'b1;
        n = 0; while (tx_ready !== 1'b0 && n < 300) begin @(negedge clk); #1; n++; end
        if (n >= 300) ok = 1'b0;
        tx_data = 8'hFF;
        n = 0; while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
        if (n >= 300) ok = 1'b0;
        n = 0; while (tx_ready !== 1'b0 && n < 300) begin @(negedge clk); #1; n++; end
        if (n >= 300) ok = 1'b0;
        tx_valid = 1'b0;
        n = 0; while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
        if (n >= 300) ok = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got handshake stall expected two frames"); end
        checks++; if (gap_q.size() - g0 !== 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", gap_q.size() - g0); end
        if (gap_q.size() - g0 >= 2) begin
            checks++; if (gap_q[g0 + 1] < HP) begin errors++; $display("FAIL b2b_ss_gap: got %0d expected >=%0d", gap_q[g0 + 1], HP); end
        end
        checks++; if (mosi_q.size() - m0 !== 16) begin errors++; $display("FAIL b2b_bits: got %0d expected 16", mosi_q.size() - m0); end
        for (int i = 0; i < 16; i++) begin
            if (mosi_q.size() > m0 + i) begin
                checks++;
                if (mosi_q[m0 + i] !== ((i < 8) ? exp_mosi(8'h00, i) : exp_mosi(8'hFF, i - 8))) begin
                    errors++; $display("FAIL b2b_mosi_bit%0d: got %b expected %b", i, mosi_q[m0 + i], (i >= 8));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int r0, q0, n, m0, lat;
        logic [7:0] resp;
        r0 = rises; q0 = rx_q.size(); n = 0;
        @(negedge clk); #1;
        tx_data = 8'h5A; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        while (rises - r0 < 3 && n < 300) begin @(negedge clk); #1; n++; end
        checks++; if (rises - r0 !== 3) begin errors++; $display("FAIL mid_third_rise: got %0d rises expected 3", rises - r0); end
        #1 rst = 1'b1;
        #1;
        checks++; if (SS !== 1'b1 || SCK !== 1'b0) begin
            errors++; $display("FAIL mid_reset_lines: got SS=%b SCK=%b expected 1/0", SS, SCK);
        end
        checks++; if (tx_ready !== 1'b1 || MOSI !== 1'b1) begin
            errors++; $display("FAIL mid_reset_ready: got ready=%b MOSI=%b expected 1/1", tx_ready, MOSI);
        end
        @(negedge clk); #1 rst = 1'b0;
        repeat (20 * HP) @(negedge clk);
        #1;
        checks++; if (rx_q.size() !== q0) begin errors++; $display("FAIL mid_no_rx_valid: got %0d pulses expected 0", rx_q.size() - q0); end
        resp = 8'($urandom);
        m0 = mosi_q.size(); q0 = rx_q.size();
        run_frame(8'h5A, resp, 1'b0, lat);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mosi_q.size() <= m0 + i || mosi_q[m0 + i] !== exp_mosi(8'h5A, i)) begin
                errors++; $display("FAIL mid_5a_mosi_bit%0d: expected %b", i, exp_mosi(8'h5A, i));
            end
        end
        checks++;
        if (rx_q.size() - q0 !== 1 || rx_q[q0] !== resp) begin
            errors++; $display("FAIL mid_5a_rx: got %h expected %h", rx_data, resp);
        end
    endtask

    task automatic test_random();
        logic [7:0] b, resp;
        int m0, q0, lat;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom); resp = 8'($urandom_range(0, 255));
            m0 = mosi_q.size(); q0 = rx_q.size();
            run_frame(b, resp, 1'b0, lat);
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mosi_q.size() <= m0 + i || mosi_q[m0 + i] !== exp_mosi(b, i)) begin
                    errors++; $display("FAIL rand%0d_mosi_bit%0d: tx=%h expected %b", k, i, b, exp_mosi(b, i));
                end
            end
            checks++;
            if (rx_q.size() - q0 !== 1 || rx_q[q0] !== resp) begin
                errors++; $display("FAIL rand%0d_rx: got %h expected %h", k, rx_data, resp);
            end
            checks++; if (lat !== 18 * HP + 1) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, 18 * HP + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_loopback();
        test_slave_response();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
- Synthesizable SPI master that serializes one byte per frame onto SS/SCK/MOSI and captures the returned MISO byte in the same frame.
- Mirrors the host-side link used to drive digit_recognizer_final:
  - SS is asserted low for each byte and SCK idles low.
  - Data is LSB first.
  - MOSI changes on the SCK falling edge and is sampled on the SCK rising edge.
- Sits in a host or FPGA-side wrapper. A command/image sequencer feeds it bytes: 0x00 header, 72 pixel bytes, 0xFF trigger, then a read.

Parameters:
- HALF_PERIOD, 8, clk cycles per SCK half-period; must be >=2 (8 at 200 MHz clk gives about 80 ns SCK period).
- BYTE_W, 8, bits per frame.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- tx_data  input  8  byte to send
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high when a new byte can be accepted
- rx_data  output  8  byte captured from MISO in the last frame
- rx_valid  output  1  one-cycle pulse; rx_data is valid
- busy  output  1  frame in progress (the inverse of tx_ready)
- SCK  output  1  serial clock, idles low
- SS  output  1  slave select, active low
- MOSI  output  1  serial data out, idles high
- MISO  input  1  serial data in

Behaviour:
- Reset (asynchronous, any state): SCK=0, SS=1, MOSI=1, tx_ready=1, busy=0, rx_valid=0, rx_data=0x00, state=IDLE, all counters=0.
- Every state after IDLE lasts exactly HALF_PERIOD clk cycles, timed by the half-period counter.
- IDLE:
  - tx_ready=1.
  - On tx_valid && tx_ready: latch tx_data into the tx shift register, clear bit_cnt and the rx shift register.
  - Next cycle: SS=0, MOSI=tx[0], SCK=0, tx_ready=0, go to LOW.
- LOW: SCK=0. At the end of the phase:
  - SCK goes to 1.
  - On that same edge, MISO is shifted into rx_shift[7] and the register shifts right. After 8 bits, bit 0 is the first bit received.
  - Go to HIGH.
- HIGH: SCK=1. At the end of the phase, SCK goes to 0, then:
  - If bit_cnt==7, go to TRAIL.
  - Otherwise increment bit_cnt, MOSI takes the next tx bit, go to LOW.
- TRAIL: SCK=0, SS=0. At the end of the phase:
  - SS=1, MOSI=1.
  - rx_data is loaded from rx_shift and rx_valid pulses for one cycle.
  - Go to GAP.
- GAP: SS=1. At the end of the phase, go to IDLE with tx_ready=1.
- Frame timing:
  - SS is low for exactly 17*HALF_PERIOD cycles.
  - Each frame has exactly 8 SCK rising edges.
  - From accept to the next tx_ready=1 takes 18*HALF_PERIOD+1 cycles.
- tx_valid is ignored while tx_ready=0; a held tx_valid starts the next frame from IDLE.
- rx_data holds its value until the next frame completes.
- MISO is not synchronized. HALF_PERIOD must exceed the slave's MISO output latency in clk cycles.
- Reset mid-frame: SS goes high and SCK low immediately, no rx_valid is produced, and the partial rx byte is discarded.

Optional Feature:
- Macro SPI_BYTE_MASTER_MSB_FIRST_EN.
  - Defined: MOSI sends tx[7] first, and MISO shifts into rx_shift[0] with a left shift, so the first bit received becomes rx_data[7].
  - Undefined (default): LSB first on both MOSI and MISO, as described above.
- Frame timing is identical in both modes.

Decomposition:
- Package spi_master_pkg holds:
  - state enum {IDLE, LOW, HIGH, TRAIL, GAP};
  - localparams BYTE_W=8, DEFAULT_HALF_PERIOD=8, MOSI_IDLE=1'b1.
- Sub-module sck_half_timer(clk, rst, start, done): reloads on start and pulses done after HALF_PERIOD cycles.
- The FSM and both shift registers stay in spi_byte_master.

Test Plan:
- Reset: assert rst mid-clock -> SCK=0, SS=1, MOSI=1, tx_ready=1, rx_valid=0, rx_data=0x00 with no clk edge required.
- Send 0xA5 with HALF_PERIOD=4 ->
  - MOSI at the 8 SCK rises reads 1,0,1,0,0,1,0,1;
  - SS low for 68 cycles;
  - exactly 8 SCK rises;
  - tx_ready returns 73 cycles after accept.
- Loopback MISO=MOSI, send 0x3C -> one rx_valid pulse at the SS rise with rx_data=0x3C.
- Slave model answering 0x07 (LSB first on MISO) while sending 0x01 -> rx_data=0x07.
- tx_valid held high with 0x00 then 0xFF ->
  - two frames;
  - SS high for >=HALF_PERIOD cycles between them;
  - second byte is sent only after tx_ready.
- rst pulse after the 3rd SCK rise -> SS=1 and SCK=0 immediately, no rx_valid; the next 0x5A frame is correct.
- With SPI_BYTE_MASTER_MSB_FIRST_EN defined, send 0xA5 -> MOSI order reads 1,0,1,0,0,1,0,1 (MSB first); loopback gives rx_data=0xA5.
